// File: rtl/cpu_player_if.sv
// cpu_player bus: enable tick and difficulty in,
// press pulse and LFSR value out.
interface cpu_player_if #(
  parameter int WIDTH = 10
);
  logic             enable;
  logic [WIDTH-1:0] difficulty;
  logic             press;
  logic [WIDTH-1:0] lfsr_value;

  modport master (
    output enable,
    output difficulty,
    input  press,
    input  lfsr_value
  );

  modport slave (
    input  enable,
    input  difficulty,
    output press,
    output lfsr_value
  );
endinterface

// File: rtl/cpu_player.sv
// Computer opponent: LFSR draw vs difficulty
// gives a one-clock press, then a cooldown.
module cpu_player #(
  parameter int             WIDTH   = 10,
  parameter int             HOLDOFF = 4,
  parameter logic [WIDTH-1:0] SEED  = 10'b0000000001
) (
  input  logic        clk,
  input  logic        reset,
  cpu_player_if.slave bus
);

  localparam logic [1:0] S_READY = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_COOL  = 2'd2;

  localparam int TAP = WIDTH - 4;
  localparam logic [7:0] CNT_LOAD = 8'(HOLDOFF - 1);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             hit;

  // x^10 + x^7 + 1, shifting left
  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.enable) begin
      lfsr_d = {lfsr_q[WIDTH-2:0],
                lfsr_q[WIDTH-1] ^ lfsr_q[TAP]};
    end
  end

  assign hit = (bus.difficulty > lfsr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_READY: begin
        if (bus.enable && hit) begin
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        state_d = S_COOL;
        cnt_d   = CNT_LOAD;
      end
      S_COOL: begin
        if (bus.enable) begin
          if (cnt_q == 8'd0) begin
            state_d = S_READY;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = S_READY;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign press_d = (state_d == S_PRESS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q  <= SEED;
      state_q <= S_READY;
      cnt_q   <= 8'd0;
      press_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign bus.press      = press_q;
  assign bus.lfsr_value = lfsr_q;

endmodule
